mul_pipe_regs: RTL and testbench
================================

// Module: mul_pipe_regs
// PURPOSE
//  Parametrised elastic register chain for the multiplier pipeline (M1..Mn), carrying
//  product, ROB index, exception vector and instr type with a per-stage valid bit.
//  Replaces the fixed per-stage M-stage register files. Adds valid/ready backpressure
//  toward writeback/ROB and a synchronous flush. Sits between the multiplier datapath
//  and the writeback arbiter.
// PARAMETERS
//  DEPTH      4   number of register stages; latency in cycles; legal range >= 1
//  DATA_W     32  width of the mul_out payload
//  ROB_IDX_W  4   width of the ROB index
//  EXC_W      3   width of the exception vector
//  TYPE_W     3   width of the instr type; 0 = not mul
// PORTS
//  clk                  in   1                clock, rising edge
//  reset                in   1                asynchronous, active-high
//  flush                in   1                synchronous kill of all in-flight entries
//  in_valid             in   1                upstream entry present
//  in_ready             out  1                chain accepts the entry this cycle
//  in_mul_out           in   DATA_W           product payload
//  in_rob_idx           in   ROB_IDX_W        ROB tag
//  in_exception_vector  in   EXC_W            exception flags
//  in_instr_type        in   TYPE_W           instruction type
//  out_valid            out  1                last stage holds a live entry
//  out_ready            in   1                downstream accepts the entry
//  out_mul_out / out_rob_idx / out_exception_vector / out_instr_type
//                       out  as inputs        payload of the last stage
//  occupancy            out  $clog2(DEPTH+1)  number of valid stages
// BEHAVIOUR
//  - Reset (async): all valid bits 0; all payload registers 0, so out_* = 0 and
//    out_instr_type = 0. occupancy = 0, out_valid = 0. A reset mid-operation drops
//    every entry with no partial writeback.
//  - Stage s (0..DEPTH-1) holds v[s] and payload p[s]. Stage 0 is fed from in_*.
//    Outputs come from stage DEPTH-1.
//  - Advance (base): adv = !v[DEPTH-1] | out_ready. It applies to all stages at once.
//    in_ready = adv.
//  - On an adv edge:
//      v[0] <= in_valid & ~flush
//      v[s] <= v[s-1] & ~flush
//  - p[s] loads only when adv = 1 and the incoming valid = 1. Otherwise p[s] holds
//    its value (no bubble overwrite).
//  - When adv = 0, all v[s] and p[s] hold. flush still clears all v[s].
//  - Latency with no stall: an entry accepted at edge N shows at the output after
//    edge N+DEPTH-1. It is visible from cycle N+DEPTH-1.
//  - out_valid = v[DEPTH-1] & ~flush. No output transfer occurs in a flush cycle.
//  - An input accepted in a flush cycle is dropped.
//  - flush and reset never alter payload registers except the reset clear.
//  - Full chain with out_ready = 0: in_ready = 0, contents frozen, no loss or
//    duplication.
//  - out_ready is sampled only when out_valid = 1. Payload stays stable while
//    out_valid = 1 and out_ready = 0.
//  - occupancy = popcount(v), combinational from registers; never exceeds DEPTH.
//  - DEPTH = 1 gives a single skid-less register with a valid/ready handshake.
// CONFIGURATION
//  - BUBBLE_COLLAPSE_EN defined: advance is per stage.
//      adv[DEPTH-1] = !v[DEPTH-1] | out_ready
//      adv[s]       = !v[s] | adv[s+1]
//      in_ready     = adv[0]
//    An invalid stage fills from upstream even while later stages stall. With the
//    output stalled, the chain compacts until occupancy = DEPTH.
//  - BUBBLE_COLLAPSE_EN undefined: the global adv above is used. Bubbles behind a
//    stalled head persist.
//  - Flush, reset and payload-hold rules are identical in both builds.
// TESTING
//  1. Reset, then in_valid = 1 with rob_idx 0..7 every cycle, out_ready = 1, DEPTH = 4
//     -> out_valid rises 3 cycles after the first accept; rob_idx 0..7 in order, no
//     gaps; occupancy steady at 4.
//  2. Chain full and out_ready = 0 for 5 cycles
//     -> in_ready = 0, out_rob_idx frozen, occupancy = 4; on release, entries drain in
//     order with none lost.
//  3. Entries at stages 0 and 2, out_ready = 0, in_valid = 1
//     -> with BUBBLE_COLLAPSE_EN, in_ready = 1 and occupancy goes 2->3->4;
//     without it, in_ready = 0 while the head is blocked.
//  4. flush = 1 with occupancy = 3 and in_valid = 1
//     -> out_valid = 0 in that cycle; occupancy = 0 next cycle; the flushed-cycle input
//     never appears.
//  5. Async reset asserted mid-cycle with occupancy = 4, mul_out = 0xDEADBEEF at output
//     -> out_valid, out_mul_out and occupancy = 0 immediately, without waiting for a
//     clock edge.
//  6. DEPTH = 1, alternate in_valid/out_ready patterns
//     -> one-cycle latency; payload held while stalled; exc vector 3'b101 and type 3'd2
//     pass unchanged.

Source files
------------

// File: rtl/mul_pipe_regs.sv
// mul_pipe_regs: elastic valid/ready register chain carrying multiplier results toward writeback.
// Optional macro BUBBLE_COLLAPSE_EN: per-stage advance so empty stages refill behind a stalled head.
module mul_pipe_regs #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned EXC_W     = 3,
    parameter int unsigned TYPE_W    = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_mul_out,
    input  logic [ROB_IDX_W-1:0]       in_rob_idx,
    input  logic [EXC_W-1:0]           in_exception_vector,
    input  logic [TYPE_W-1:0]          in_instr_type,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_mul_out,
    output logic [ROB_IDX_W-1:0]       out_rob_idx,
    output logic [EXC_W-1:0]           out_exception_vector,
    output logic [TYPE_W-1:0]          out_instr_type,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0]    mul_out;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [EXC_W-1:0]     exception_vector;
        logic [TYPE_W-1:0]    instr_type;
    } entry_t;

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_in;
    logic [DEPTH-1:0] adv;
    entry_t           p    [DEPTH];
    entry_t           p_in [DEPTH];
    entry_t           in_entry;

    assign in_entry = {in_mul_out, in_rob_idx, in_exception_vector, in_instr_type};

    // What each stage would take on an advance: stage 0 from the input port, others from upstream
    always_comb begin
        v_in    = '0;
        v_in[0] = in_valid;
        p_in[0] = in_entry;
        for (int s = 1; s < int'(DEPTH); s++) begin
            v_in[s] = v[s-1];
            p_in[s] = p[s-1];
        end
    end

`ifdef BUBBLE_COLLAPSE_EN
    // A stage may advance if it, or any stage downstream of it, has room (or the head drains)
    always_comb begin
        logic room;
        room = out_ready;
        adv  = '0;
        for (int s = int'(DEPTH) - 1; s >= 0; s--) begin
            room   = room | ~v[s];
            adv[s] = room;
        end
    end
`else
    // Whole chain moves in lockstep; bubbles behind a stalled head stay put
    always_comb begin
        adv = {DEPTH{~v[DEPTH-1] | out_ready}};
    end
`endif

    // Valid bits: flush kills everything regardless of stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
        end else begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                if (flush) begin
                    v[s] <= 1'b0;
                end else if (adv[s]) begin
                    v[s] <= v_in[s];
                end
            end
        end
    end

    // Payload only loads with a live incoming entry, so bubbles never overwrite data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                p[s] <= '0;
            end
        end else begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                if (adv[s] && v_in[s]) begin
                    p[s] <= p_in[s];
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int s = 0; s < int'(DEPTH); s++) begin
            occupancy = occupancy + OCC_W'(v[s]);
        end
    end

    assign in_ready             = adv[0];
    assign out_valid            = v[DEPTH-1] & ~flush;
    assign out_mul_out          = p[DEPTH-1].mul_out;
    assign out_rob_idx          = p[DEPTH-1].rob_idx;
    assign out_exception_vector = p[DEPTH-1].exception_vector;
    assign out_instr_type       = p[DEPTH-1].instr_type;

endmodule

// File: tb/tb_mul_pipe_regs.sv
// tb_mul_pipe_regs: scoreboard bench for mul_pipe_regs, DEPTH=4 chain plus a DEPTH=1 instance.
// The chain is modelled as an ordered queue of accepted entries.
module tb_mul_pipe_regs;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ENT_W = 42;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_mul_out, out_mul_out;
    logic [3:0]  in_rob_idx, out_rob_idx;
    logic [2:0]  in_exception_vector, out_exception_vector;
    logic [2:0]  in_instr_type, out_instr_type;
    logic [2:0]  occupancy;

    logic        d1_flush, d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
    logic [31:0] d1_in_mul_out, d1_out_mul_out;
    logic [3:0]  d1_in_rob_idx, d1_out_rob_idx;
    logic [2:0]  d1_in_exc, d1_out_exc, d1_in_type, d1_out_type;
    logic [0:0]  d1_occupancy;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [ENT_W-1:0] exp_q [$];

    mul_pipe_regs #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mul_out(in_mul_out), .in_rob_idx(in_rob_idx),
        .in_exception_vector(in_exception_vector), .in_instr_type(in_instr_type),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mul_out(out_mul_out), .out_rob_idx(out_rob_idx),
        .out_exception_vector(out_exception_vector), .out_instr_type(out_instr_type),
        .occupancy(occupancy)
    );

    mul_pipe_regs #(.DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .flush(d1_flush),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .in_mul_out(d1_in_mul_out), .in_rob_idx(d1_in_rob_idx),
        .in_exception_vector(d1_in_exc), .in_instr_type(d1_in_type),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .out_mul_out(d1_out_mul_out), .out_rob_idx(d1_out_rob_idx),
        .out_exception_vector(d1_out_exc), .out_instr_type(d1_out_type),
        .occupancy(d1_occupancy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl);
        in_valid            = iv;
        out_ready           = ordy;
        flush               = fl;
        in_mul_out          = $urandom;
        in_rob_idx          = 4'($urandom);
        in_exception_vector = 3'($urandom);
        in_instr_type       = 3'($urandom);
    endtask

    task automatic d1_drive(input logic iv, input logic ordy, input logic fl, input logic [41:0] pl);
        d1_in_valid  = iv;
        d1_out_ready = ordy;
        d1_flush     = fl;
        {d1_in_mul_out, d1_in_rob_idx, d1_in_exc, d1_in_type} = pl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end
    endtask

    // Producer side: record each entry the chain accepts
    always @(negedge clk) begin
        #1;
        if (!reset && in_valid && in_ready && !flush)
            exp_q.push_back({in_mul_out, in_rob_idx, in_exception_vector, in_instr_type});
    end

    // Consumer side: compare what the chain presents against the oldest accepted entry
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            check("sb_occupancy", 64'(occupancy), 64'(exp_q.size()));
            if (exp_q.size() == 0) check("sb_idle_out_valid", 64'(out_valid), 64'(0));
            if (flush) check("sb_flush_out_valid", 64'(out_valid), 64'(0));
            if (out_valid && exp_q.size() > 0)
                check("sb_out_payload",
                      64'({out_mul_out, out_rob_idx, out_exception_vector, out_instr_type}),
                      64'(exp_q[0]));
            if (out_ready) check("sb_in_ready_drain", 64'(in_ready), 64'(1));
`ifdef BUBBLE_COLLAPSE_EN
            else check("sb_in_ready_room", 64'(in_ready), 64'(exp_q.size() < int'(DEPTH)));
`else
            else if (exp_q.size() == int'(DEPTH)) check("sb_in_ready_full", 64'(in_ready), 64'(0));
`endif
            if (flush) exp_q.delete();
            else if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first_seen;
        logic [31:0] head_mul;
        logic [41:0] pl0, pl1;
        pl0 = {32'h1111_2222, 4'h5, 3'b101, 3'd2};
        pl1 = {32'hA5A5_0F0F, 4'hA, 3'b010, 3'd1};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        d1_drive(1'b0, 1'b0, 1'b0, 42'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_out_mul", 64'(out_mul_out), 64'(0));
        check("rst_out_type", 64'(out_instr_type), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_d1_out_valid", 64'(d1_out_valid), 64'(0));

        // Streaming with no stall: 3-edge latency, no gaps, full chain
        first_seen = -1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            drive(i < 8, 1'b1, 1'b0);
            in_rob_idx = 4'(i);
            @(negedge clk);
            if (out_valid && first_seen < 0) first_seen = i;
            if (i >= 4 && i <= 11) begin
                check("t1_no_gap", 64'(out_valid), 64'(1));
                check("t1_rob_order", 64'(out_rob_idx), 64'(i - 4));
            end
            if (i >= 4 && i <= 8) check("t1_occ_steady", 64'(occupancy), 64'(4));
        end
        check("t1_latency", 64'(first_seen - 1), 64'(3));

        // Full chain stalled: frozen head, no acceptance, then ordered drain
        head_mul = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(1'b1, 1'b0, 1'b0);
            if (i == 0) head_mul = in_mul_out;
            @(negedge clk);
            if (i >= 4) begin
                check("t2_in_ready", 64'(in_ready), 64'(0));
                check("t2_occ", 64'(occupancy), 64'(4));
                check("t2_head_frozen", 64'(out_mul_out), 64'(head_mul));
            end
        end
        idle(8);
        check("t2_drained", 64'(exp_q.size()), 64'(0));

        // Bubble behind a stalled head
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            drive(j != 1, j < 3, 1'b0);
            @(negedge clk);
            if (j == 3) begin
                check("t3_occ_a", 64'(occupancy), 64'(2));
                check("t3_in_ready_a", 64'(in_ready), 64'(1));
            end
            if (j == 4) begin
                check("t3_occ_b", 64'(occupancy), 64'(3));
`ifdef BUBBLE_COLLAPSE_EN
                check("t3_in_ready_b", 64'(in_ready), 64'(1));
`else
                check("t3_in_ready_b", 64'(in_ready), 64'(0));
`endif
            end
            if (j == 5) begin
`ifdef BUBBLE_COLLAPSE_EN
                check("t3_occ_c", 64'(occupancy), 64'(4));
`else
                check("t3_occ_c", 64'(occupancy), 64'(3));
`endif
                check("t3_in_ready_c", 64'(in_ready), 64'(0));
            end
        end
        idle(8);
        check("t3_drained", 64'(exp_q.size()), 64'(0));

        // Flush with three live entries and a concurrent input
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            drive(j != 2, j == 4, j == 4);
            @(negedge clk);
            if (j == 4) begin
                check("t4_flush_out_valid", 64'(out_valid), 64'(0));
                check("t4_occ_before", 64'(occupancy), 64'(3));
            end
        end
        for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            drive(1'b0, 1'b1, 1'b0);
            @(negedge clk);
            if (j == 0) check("t4_occ_after", 64'(occupancy), 64'(0));
            check("t4_nothing_emerges", 64'(out_valid), 64'(0));
        end

        // Async reset mid-cycle with a full chain
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(1'b1, 1'b0, 1'b0);
            if (i == 0) in_mul_out = 32'hDEADBEEF;
            @(negedge clk);
        end
        check("t5_pre_valid", 64'(out_valid), 64'(1));
        check("t5_pre_mul", 64'(out_mul_out), 64'(32'hDEADBEEF));
        check("t5_pre_occ", 64'(occupancy), 64'(4));
        @(posedge clk); #3;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("t5_out_valid", 64'(out_valid), 64'(0));
        check("t5_out_mul", 64'(out_mul_out), 64'(0));
        check("t5_occ", 64'(occupancy), 64'(0));
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk); #2;
        reset = 1'b0;

        // Randomized traffic with stalls and occasional flushes
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
        end
        idle(10);
        check("rand_drained", 64'(exp_q.size()), 64'(0));

        // DEPTH=1: one-cycle latency, hold under stall, field pass-through
        for (int j = 0; j < 9; j++) begin
            @(posedge clk); #1;
            case (j)
                0:       d1_drive(1'b1, 1'b0, 1'b0, pl0);
                1, 2:    d1_drive(1'b1, 1'b0, 1'b0, pl1);
                3:       d1_drive(1'b1, 1'b1, 1'b0, pl1);
                6:       d1_drive(1'b1, 1'b1, 1'b1, pl0);
                default: d1_drive(1'b0, 1'b1, 1'b0, pl0);
            endcase
            @(negedge clk);
            case (j)
                0: begin
                    check("t6_empty_valid", 64'(d1_out_valid), 64'(0));
                    check("t6_empty_ready", 64'(d1_in_ready), 64'(1));
                end
                1: begin
                    check("t6_lat1_valid", 64'(d1_out_valid), 64'(1));
                    check("t6_lat1_payload",
                          64'({d1_out_mul_out, d1_out_rob_idx, d1_out_exc, d1_out_type}), 64'(pl0));
                    check("t6_exc", 64'(d1_out_exc), 64'(3'b101));
                    check("t6_type", 64'(d1_out_type), 64'(3'd2));
                    check("t6_full_ready", 64'(d1_in_ready), 64'(0));
                    check("t6_occ_full", 64'(d1_occupancy), 64'(1));
                end
                2: begin
                    check("t6_hold_mul", 64'(d1_out_mul_out), 64'(32'h1111_2222));
                    check("t6_hold_ready", 64'(d1_in_ready), 64'(0));
                end
                3: begin
                    check("t6_release_mul", 64'(d1_out_mul_out), 64'(32'h1111_2222));
                    check("t6_release_ready", 64'(d1_in_ready), 64'(1));
                end
                4: begin
                    check("t6_next_valid", 64'(d1_out_valid), 64'(1));
                    check("t6_next_payload",
                          64'({d1_out_mul_out, d1_out_rob_idx, d1_out_exc, d1_out_type}), 64'(pl1));
                end
                5: begin
                    check("t6_drained_valid", 64'(d1_out_valid), 64'(0));
                    check("t6_bubble_hold", 64'(d1_out_mul_out), 64'(32'hA5A5_0F0F));
                    check("t6_drained_occ", 64'(d1_occupancy), 64'(0));
                end
                7, 8: begin
                    check("t6_flushed_valid", 64'(d1_out_valid), 64'(0));
                    check("t6_flushed_occ", 64'(d1_occupancy), 64'(0));
                end
                default: ;
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
